// File: rtl/ruler_solution_collector.sv
// Golomb-ruler solution collector: detects a completed ruler on the mark chain,
// queues it in a small FIFO and shrinks the shared search bound on each accepted ruler.
module ruler_solution_collector #(
  parameter int unsigned NUMPOSITIONS = 5,
  parameter int unsigned MAXVALUE     = 500,
  parameter int unsigned DEPTH        = 4,
  parameter bit          SHRINK       = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [8:0]                    initlimit,
  input  logic [6:0]                    enabled,
  input  logic                          ready_in,
  input  logic [(NUMPOSITIONS+1)*9-1:0] marks_in,
  output logic [8:0]                    limit,
  output logic                          sol_valid,
  input  logic                          sol_ready,
  output logic [(NUMPOSITIONS+1)*9-1:0] sol_marks,
  output logic [8:0]                    sol_length,
  output logic [15:0]                   sol_count,
  output logic [7:0]                    drop_count,
  output logic                          search_done
);

  localparam int unsigned MW       = (NUMPOSITIONS + 1) * 9;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [6:0]  FULLBUS  = 7'(NUMPOSITIONS + 1);
  localparam logic [8:0]  MAXV     = 9'(MAXVALUE);
  localparam logic [AW:0] FULLCNT  = (AW + 1)'(DEPTH);

  logic [8:0]    limit_q, limit_d;
  logic          hit_q, hit_d;
  logic          done_q, done_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [15:0]   solcnt_q, solcnt_d;
  logic [7:0]    drop_q, drop_d;
  logic [MW-1:0] mem_q [DEPTH];

  logic       hit, event_fire, accept, full, pop, push;
  logic [8:0] len;

  always_comb begin
    hit        = ready_in && (enabled == FULLBUS);
    event_fire = hit && !hit_q;
    len        = marks_in[9:1];
    accept     = event_fire && (len != '0) && (len <= limit_q);
    full       = (cnt_q == FULLCNT);
    pop        = (cnt_q != '0) && sol_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    push       = accept && (!full || pop);
  end

  always_comb begin
    limit_d  = limit_q;
    hit_d    = hit_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    solcnt_d = solcnt_q;
    drop_d   = drop_q;

    if (ready_in) begin
      hit_d = hit;
    end
    if (ready_in && (enabled == '0)) begin
      done_d = 1'b1;
    end
    if (accept) begin
      solcnt_d = (solcnt_q == '1) ? solcnt_q : solcnt_q + 16'd1;
      if (SHRINK) begin
        limit_d = len - 9'd1;
      end
      if (!push) begin
        drop_d = (drop_q == '1) ? drop_q : drop_q + 8'd1;
      end
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      limit_q  <= (initlimit > MAXV) ? MAXV : initlimit;
      hit_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      solcnt_q <= '0;
      drop_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      limit_q  <= limit_d;
      hit_q    <= hit_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      solcnt_q <= solcnt_d;
      drop_q   <= drop_d;
      if (push) begin
        mem_q[wr_q] <= marks_in;
      end
    end
  end

  assign limit       = limit_q;
  assign sol_valid   = (cnt_q != '0);
  assign sol_marks   = mem_q[rd_q];
  assign sol_length  = mem_q[rd_q][9:1];
  assign sol_count   = solcnt_q;
  assign drop_count  = drop_q;
  assign search_done = done_q;

endmodule

// File: tb/tb_ruler_solution_collector.sv
// Bench for ruler_solution_collector: two instances (shrinking and enumerating) share
// stimulus and are checked every cycle against a queue-style behavioural model.
module tb_ruler_solution_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  initlimit;
  logic [6:0]  enabled;
  logic        ready_in;
  logic [53:0] marks_in;
  logic        sol_ready;

  logic [8:0]  lim0, lim1, len0, len1;
  logic        val0, val1, dn0, dn1;
  logic [53:0] mk0, mk1;
  logic [15:0] sc0, sc1;
  logic [7:0]  dc0, dc1;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  ruler_solution_collector #(.NUMPOSITIONS(5), .MAXVALUE(500), .DEPTH(4), .SHRINK(1'b1)) dut0 (
    .clock(clock), .reset(reset), .initlimit(initlimit), .enabled(enabled),
    .ready_in(ready_in), .marks_in(marks_in), .limit(lim0), .sol_valid(val0),
    .sol_ready(sol_ready), .sol_marks(mk0), .sol_length(len0), .sol_count(sc0),
    .drop_count(dc0), .search_done(dn0));

  ruler_solution_collector #(.NUMPOSITIONS(5), .MAXVALUE(500), .DEPTH(4), .SHRINK(1'b0)) dut1 (
    .clock(clock), .reset(reset), .initlimit(initlimit), .enabled(enabled),
    .ready_in(ready_in), .marks_in(marks_in), .limit(lim1), .sol_valid(val1),
    .sol_ready(sol_ready), .sol_marks(mk1), .sol_length(len1), .sol_count(sc1),
    .drop_count(dc1), .search_done(dn1));

  // Behavioural model: index 0 shrinks the bound, index 1 keeps it fixed.
  logic [53:0] mbuf [2][4];
  int          mcnt [2];
  int          mlim [2];
  int          msol [2];
  int          mdrop[2];
  bit          mclean[2];
  bit          mhitq, mdone, mvalid = 1'b0;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Marks packed so that m[5] lands in bits [9:1].
  function automatic logic [53:0] pack(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5);
    logic [53:0] v;
    v = {9'(a0), 9'(a1), 9'(a2), 9'(a3), 9'(a4), 9'(a5)};
    return v << 1;
  endfunction

  task automatic model_step();
    bit hit, ev, acc;
    int L;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mlim[i]   = (initlimit > 500) ? 500 : int'(initlimit);
        mcnt[i]   = 0;
        msol[i]   = 0;
        mdrop[i]  = 0;
        mclean[i] = 1'b1;
      end
      mhitq  = 1'b0;
      mdone  = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      hit = ready_in && (enabled == 7'd6);
      ev  = hit && !mhitq;
      if (ready_in) mhitq = hit;
      if (ready_in && enabled == 7'd0) mdone = 1'b1;
      L = int'(marks_in[9:1]);
      for (int i = 0; i < 2; i++) begin
        acc = ev && L != 0 && L <= mlim[i];
        if (mcnt[i] > 0 && sol_ready) begin
          for (int k = 0; k < 3; k++) mbuf[i][k] = mbuf[i][k+1];
          mcnt[i]--;
        end
        if (acc) begin
          if (msol[i] < 65535) msol[i]++;
          if (i == 0) mlim[i] = L - 1;
          if (mcnt[i] < 4) begin
            mbuf[i][mcnt[i]] = marks_in;
            mcnt[i]++;
            mclean[i] = 1'b0;
          end else if (mdrop[i] < 255) begin
            mdrop[i]++;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [8:0] lim, input logic v, input logic [53:0] mk,
                          input logic [8:0] ln, input logic [15:0] sc, input logic [7:0] dc,
                          input logic dn);
    chk("limit", i, 64'(lim), 64'(mlim[i]));
    chk("sol_valid", i, 64'(v), 64'(mcnt[i] > 0));
    if (mcnt[i] > 0) begin
      chk("sol_marks", i, 64'(mk), 64'(mbuf[i][0]));
      chk("sol_length", i, 64'(ln), 64'(mbuf[i][0][9:1]));
    end else if (mclean[i]) begin
      chk("sol_marks_rst", i, 64'(mk), 64'd0);
      chk("sol_length_rst", i, 64'(ln), 64'd0);
    end
    chk("sol_count", i, 64'(sc), 64'(msol[i]));
    chk("drop_count", i, 64'(dc), 64'(mdrop[i]));
    chk("search_done", i, 64'(dn), 64'(mdone));
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (mvalid) begin
      cmp_inst(0, lim0, val0, mk0, len0, sc0, dc0, dn0);
      cmp_inst(1, lim1, val1, mk1, len1, sc1, dc1, dn1);
    end
  end

  task automatic drive(input int en, input bit rdy, input logic [53:0] mk);
    @(negedge clock);
    enabled  = 7'(en);
    ready_in = rdy;
    marks_in = mk;
  endtask

  task automatic do_reset(input int lim);
    @(negedge clock);
    reset     = 1'b1;
    initlimit = 9'(lim);
    enabled   = 7'd5;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [53:0] v;
    logic [63:0] r64;
    reset = 1'b1; initlimit = 9'd40; enabled = 7'd5; ready_in = 1'b0;
    marks_in = '0; sol_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("lit_reset_limit", 0, 64'(lim0), 64'd40);
    chk("lit_reset_valid", 0, 64'(val0), 64'd0);

    // Held bus gives a single event; bound shrinks to L-1.
    v = pack(0, 1, 4, 10, 12, 17);
    repeat (3) drive(6, 1'b1, v);
    drive(5, 1'b1, v);
    chk("lit_t1_count", 0, 64'(sc0), 64'd1);
    chk("lit_t1_limit", 0, 64'(lim0), 64'd16);
    chk("lit_t1_valid", 0, 64'(val0), 64'd1);
    chk("lit_t1_length", 0, 64'(len0), 64'd17);
    chk("lit_t1_marks", 0, 64'(mk0), 64'(v));
    chk("lit_t1_limit_fixed", 1, 64'(lim1), 64'd40);

    // Stale ruler above the bound is rejected, then an in-bound one accepted.
    drive(6, 1'b1, v);
    drive(5, 1'b1, v);
    chk("lit_t2_reject", 0, 64'(sc0), 64'd1);
    chk("lit_t2_enum", 1, 64'(sc1), 64'd2);
    v = pack(0, 1, 4, 10, 12, 16);
    drive(6, 1'b1, v);
    drive(5, 1'b1, v);
    chk("lit_t2_count", 0, 64'(sc0), 64'd2);
    chk("lit_t2_limit", 0, 64'(lim0), 64'd15);

    // Five events into a 4-deep FIFO with no consumer.
    do_reset(40);
    for (int k = 0; k < 5; k++) begin
      v = pack(0, 2, 5, 11, 20, 30 + k);
      drive(6, 1'b1, v);
      drive(5, 1'b1, v);
    end
    chk("lit_t3_count", 1, 64'(sc1), 64'd5);
    chk("lit_t3_drop", 1, 64'(dc1), 64'd1);
    sol_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("lit_t3_order", 1, 64'(len1), 64'(30 + k));
      @(negedge clock);
    end
    chk("lit_t3_empty", 1, 64'(val1), 64'd0);
    sol_ready = 1'b0;

    // Full FIFO with a push coinciding with a pop.
    for (int k = 0; k < 4; k++) begin
      v = pack(0, 3, 7, 9, 15, 20 + k);
      drive(6, 1'b1, v);
      drive(5, 1'b1, v);
    end
    @(negedge clock);
    sol_ready = 1'b1;
    enabled   = 7'd6;
    marks_in  = pack(0, 3, 7, 9, 15, 25);
    @(negedge clock);
    sol_ready = 1'b0;
    enabled   = 7'd5;
    chk("lit_t4_nodrop", 1, 64'(dc1), 64'd1);
    chk("lit_t4_count", 1, 64'(sc1), 64'd10);
    sol_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("lit_t4_order", 1, 64'(len1), (k == 3) ? 64'd25 : 64'(21 + k));
      @(negedge clock);
    end
    sol_ready = 1'b0;

    // Edge detector: toggling bus and ready_in gating.
    do_reset(40);
    v = pack(0, 1, 3, 7, 12, 20);
    drive(6, 1'b1, v); drive(5, 1'b1, v); drive(6, 1'b1, v); drive(5, 1'b1, v);
    chk("lit_t5_toggle", 1, 64'(sc1), 64'd2);
    drive(6, 1'b0, v); drive(6, 1'b1, v); drive(6, 1'b1, v); drive(5, 1'b1, v);
    chk("lit_t5_gated", 1, 64'(sc1), 64'd3);

    // Sticky done, then reset with entries queued; clamp of initlimit.
    drive(0, 1'b1, v);
    drive(5, 1'b1, v);
    chk("lit_t6_done", 0, 64'(dn0), 64'd1);
    drive(5, 1'b1, v);
    chk("lit_t6_sticky", 1, 64'(dn1), 64'd1);
    chk("lit_t6_queued", 1, 64'(val1), 64'd1);
    do_reset(40);
    chk("lit_t6_rst_valid", 1, 64'(val1), 64'd0);
    chk("lit_t6_rst_count", 1, 64'(sc1), 64'd0);
    chk("lit_t6_rst_limit", 0, 64'(lim0), 64'd40);
    chk("lit_t6_rst_done", 0, 64'(dn0), 64'd0);
    do_reset(510);
    chk("lit_clamp", 0, 64'(lim0), 64'd500);

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 199) == 0);
      initlimit = 9'($urandom_range(0, 511));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: enabled = 7'd6;
        4, 5:       enabled = 7'd5;
        6:          enabled = 7'd4;
        7:          enabled = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'd3;
        default:    enabled = 7'($urandom_range(0, 127));
      endcase
      ready_in = ($urandom_range(0, 3) != 0);
      r64 = {$urandom, $urandom};
      r64[9:1] = 9'($urandom_range(0, 45));
      marks_in = r64[53:0];
      sol_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
